// File: rtl/fetch_sequencer_pkg.sv
// rtl/fetch_sequencer_pkg.sv - shared types and constants for the fetch sequencer
// Contents: sequencer state enum, HALT_INST encoding, width/depth defaults,
//           saturating 16-bit increment helper.
package fetch_sequencer_pkg;

  localparam int PC_W_DEF   = 10;
  localparam int LUT_N_DEF  = 32;
  localparam int MEM_TO_DEF = 16;
  localparam int KEY_W      = 5;
  localparam int INST_W     = 9;

  localparam logic [INST_W-1:0] HALT_INST = 9'h1FF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_MEM_WAIT,
    ST_HALT
  } state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - instruction/memory handshake bundle between sequencer and core
// Signals: pc_out, exec_en, mem_req (sequencer -> core);
//          inst, branch_en, memory_read_en, memory_write_en, mem_ack (core -> sequencer).
interface fetch_sequencer_if #(
  parameter int PC_W = fetch_sequencer_pkg::PC_W_DEF
);
  import fetch_sequencer_pkg::*;

  logic [PC_W-1:0]   pc_out;
  logic              exec_en;
  logic              mem_req;
  logic [INST_W-1:0] inst;
  logic              branch_en;
  logic              memory_read_en;
  logic              memory_write_en;
  logic              mem_ack;

  modport master (
    output pc_out, exec_en, mem_req,
    input  inst, branch_en, memory_read_en, memory_write_en, mem_ack
  );

  modport slave (
    input  pc_out, exec_en, mem_req,
    output inst, branch_en, memory_read_en, memory_write_en, mem_ack
  );

endinterface

// File: rtl/fetch_sequencer_branch_lut.sv
// rtl/fetch_sequencer_branch_lut.sv - branch-target table, one write port, one async read port
// Ports: clk, rst_n (async, active-low, clears all entries);
//        we/widx/wdata write port; ridx -> rdata combinational read.
module branch_lut
  import fetch_sequencer_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int LUT_N = LUT_N_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [KEY_W-1:0] widx,
  input  logic [PC_W-1:0]  wdata,
  input  logic [KEY_W-1:0] ridx,
  output logic [PC_W-1:0]  rdata
);

  logic [PC_W-1:0] mem_q [LUT_N];

  // Storage is registered, so a read in the write cycle sees the old entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LUT_N; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we && (32'(widx) < LUT_N)) begin
      mem_q[widx] <= wdata;
    end
  end

  // Keys beyond a shallow table read as target 0.
  assign rdata = (32'(ridx) < LUT_N) ? mem_q[ridx] : '0;

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - program-counter sequencer with branch LUT and memory-wait timeout
// Ports: clk, rst_n (async, active-low); start/start_addr launch a program;
//        cfg_we/cfg_idx/cfg_data write the branch LUT; done/err/instr_count status;
//        bus (master) carries pc_out, inst, decoder flags, exec_en and the mem_req/mem_ack handshake.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int PC_W   = PC_W_DEF,
  parameter int LUT_N  = LUT_N_DEF,
  parameter int MEM_TO = MEM_TO_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PC_W-1:0]  start_addr,
  input  logic             cfg_we,
  input  logic [KEY_W-1:0] cfg_idx,
  input  logic [PC_W-1:0]  cfg_data,
  output logic             done,
  output logic             err,
  output logic [15:0]      instr_count,
  fetch_sequencer_if.master bus
);

  localparam int TO_W = $clog2(MEM_TO + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TO - 1);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     count_q, count_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  logic            commit;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] lut_rdata;

  branch_lut #(
    .PC_W  (PC_W),
    .LUT_N (LUT_N)
  ) u_lut (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (cfg_we),
    .widx  (cfg_idx),
    .wdata (cfg_data),
    .ridx  (bus.inst[KEY_W-1:0]),
    .rdata (lut_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      done_q   <= done_d;
      err_q    <= err_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    count_d  = count_q;
    done_d   = done_q;
    err_d    = err_q;
    to_cnt_d = to_cnt_q;
    commit   = 1'b0;
    // Plain addition wraps the all-ones PC back to zero.
    pc_next  = bus.branch_en ? lut_rdata : pc_q + PC_W'(1);

    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = start_addr;
          count_d = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      ST_FETCH: begin
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (bus.inst == HALT_INST) begin
          done_d  = 1'b1;
          state_d = ST_HALT;
        end else if (bus.memory_read_en || bus.memory_write_en) begin
          to_cnt_d = '0;
          state_d  = ST_MEM_WAIT;
        end else begin
          commit  = 1'b1;
          pc_d    = pc_next;
          state_d = ST_FETCH;
        end
      end
      ST_MEM_WAIT: begin
        // An ack in the final allowed cycle still commits.
        if (bus.mem_ack) begin
          commit  = 1'b1;
          pc_d    = pc_next;
          state_d = ST_FETCH;
        end else if (to_cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_HALT;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (commit) begin
      count_d = sat_inc16(count_q);
    end
  end

  // mem_req is a pure state decode so reset removes it without a clock edge.
  assign bus.pc_out  = pc_q;
  assign bus.exec_en = commit;
  assign bus.mem_req = (state_q == ST_MEM_WAIT);
  assign done        = done_q;
  assign err         = err_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  localparam int PC_W = 10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start;
  logic [PC_W-1:0]  start_addr;
  logic             cfg_we;
  logic [KEY_W-1:0] cfg_idx;
  logic [PC_W-1:0]  cfg_data;
  logic             done;
  logic             err;
  logic [15:0]      instr_count;

  int n_checks = 0;
  int n_errors = 0;
  int pulses;
  int hi;
  int bad;

  fetch_sequencer_if #(.PC_W(PC_W)) bus ();

  fetch_sequencer #(
    .PC_W   (PC_W),
    .LUT_N  (32),
    .MEM_TO (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .start_addr  (start_addr),
    .cfg_we      (cfg_we),
    .cfg_idx     (cfg_idx),
    .cfg_data    (cfg_data),
    .done        (done),
    .err         (err),
    .instr_count (instr_count),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inst(input logic [8:0] i, input logic br, input logic rd, input logic wr);
    bus.inst            = i;
    bus.branch_en       = br;
    bus.memory_read_en  = rd;
    bus.memory_write_en = wr;
  endtask

  // Leaves the DUT in FETCH with pc_out = addr.
  task automatic launch(input logic [PC_W-1:0] addr);
    start      = 1'b1;
    start_addr = addr;
    tick();
    start      = 1'b0;
  endtask

  initial begin
    start      = 1'b0;
    start_addr = '0;
    cfg_we     = 1'b0;
    cfg_idx    = '0;
    cfg_data   = '0;
    bus.mem_ack = 1'b0;
    set_inst(9'h000, 1'b0, 1'b0, 1'b0);

    // Reset state, observed before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_pc",      32'(bus.pc_out),  0);
    chk("rst_exec_en", 32'(bus.exec_en), 0);
    chk("rst_mem_req", 32'(bus.mem_req), 0);
    chk("rst_done",    32'(done),        0);
    chk("rst_err",     32'(err),         0);
    chk("rst_count",   32'(instr_count), 0);
    chk("rst_state",   32'(dut.state_q), 32'(ST_IDLE));
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Three plain instructions from pc 5, then HALT; start during EXEC ignored.
    pulses = 0;
    launch(10'd5);
    chk("t1_pc_start", 32'(bus.pc_out), 5);
    for (int i = 0; i < 3; i++) begin
      tick();
      set_inst(9'h00A + 9'(i), 1'b0, 1'b0, 1'b0);
      if (i == 1) begin
        start      = 1'b1;
        start_addr = 10'h055;
      end
      #1;
      chk("t1_exec_en", 32'(bus.exec_en), 1);
      if (bus.exec_en) pulses++;
      chk("t1_pc_exec", 32'(bus.pc_out), 5 + i);
      tick();
      start = 1'b0;
      chk("t1_pc_next", 32'(bus.pc_out), 6 + i);
    end
    tick();
    set_inst(HALT_INST, 1'b0, 1'b0, 1'b0);
    #1;
    chk("t1_halt_no_commit", 32'(bus.exec_en), 0);
    tick();
    chk("t1_done",   32'(done),        1);
    chk("t1_count",  32'(instr_count), 3);
    chk("t1_pc",     32'(bus.pc_out),  8);
    chk("t1_pulses", 32'(pulses),      3);

    // Branch through LUT; same-cycle rewrite of the key reads the old target.
    cfg_we   = 1'b1;
    cfg_idx  = 5'd3;
    cfg_data = 10'h040;
    tick();
    cfg_we = 1'b0;
    launch(10'd10);
    chk("t2_pc_start", 32'(bus.pc_out), 10);
    chk("t2_done_clr", 32'(done),       0);
    chk("t2_count_clr", 32'(instr_count), 0);
    tick();
    set_inst(9'h003, 1'b1, 1'b0, 1'b0);
    cfg_we   = 1'b1;
    cfg_idx  = 5'd3;
    cfg_data = 10'h077;
    #1;
    chk("t2_exec_en", 32'(bus.exec_en), 1);
    tick();
    cfg_we = 1'b0;
    chk("t2_branch_old", 32'(bus.pc_out), 32'h040);
    tick();
    set_inst(9'h003, 1'b1, 1'b0, 1'b0);
    tick();
    chk("t2_branch_new", 32'(bus.pc_out), 32'h077);
    tick();
    set_inst(HALT_INST, 1'b0, 1'b0, 1'b0);
    tick();
    chk("t2_done",  32'(done),        1);
    chk("t2_count", 32'(instr_count), 2);

    // Load at pc 2 acknowledged in the fourth wait cycle.
    launch(10'd2);
    tick();
    set_inst(9'h010, 1'b0, 1'b1, 1'b0);
    #1;
    chk("t3_exec_no_commit", 32'(bus.exec_en), 0);
    chk("t3_req_not_yet",    32'(bus.mem_req), 0);
    tick();
    hi = 0;
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) bus.mem_ack = 1'b1;
      #1;
      if (bus.mem_req) hi++;
      chk("t3_exec_en", 32'(bus.exec_en), (k == 4) ? 1 : 0);
      tick();
    end
    bus.mem_ack = 1'b0;
    set_inst(9'h000, 1'b0, 1'b0, 1'b0);
    chk("t3_req_drop", 32'(bus.mem_req),  0);
    chk("t3_req_hi",   32'(hi),           4);
    chk("t3_pc",       32'(bus.pc_out),   3);
    chk("t3_count",    32'(instr_count),  1);
    // Stray ack in FETCH/EXEC has no effect.
    bus.mem_ack = 1'b1;
    tick();
    set_inst(HALT_INST, 1'b0, 1'b0, 1'b0);
    #1;
    chk("t3_ack_ignored", 32'(bus.exec_en), 0);
    tick();
    bus.mem_ack = 1'b0;
    chk("t3_done",  32'(done),        1);
    chk("t3_count2", 32'(instr_count), 1);

    // PC wrap, then a store that times out.
    launch(10'h3FF);
    tick();
    set_inst(9'h000, 1'b0, 1'b0, 1'b0);
    tick();
    chk("t4_wrap",  32'(bus.pc_out),  0);
    chk("t4_count", 32'(instr_count), 1);
    tick();
    set_inst(9'h021, 1'b0, 1'b0, 1'b1);
    tick();
    hi  = 0;
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      if (bus.mem_req) hi++;
      if (bus.exec_en) bad++;
      tick();
    end
    chk("t4_req_hi",  32'(hi),            16);
    chk("t4_no_exec", 32'(bad),           0);
    chk("t4_err",     32'(err),           1);
    chk("t4_req_off", 32'(bus.mem_req),   0);
    chk("t4_done",    32'(done),          0);
    chk("t4_state",   32'(dut.state_q),   32'(ST_HALT));
    chk("t4_count",   32'(instr_count),   1);

    // Restart clears err; reset mid-wait acts without a clock edge.
    launch(10'h100);
    chk("t5_err_clr", 32'(err), 0);
    tick();
    set_inst(9'h011, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    chk("t5_req_on", 32'(bus.mem_req), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_req",   32'(bus.mem_req),  0);
    chk("t5_rst_pc",    32'(bus.pc_out),   0);
    chk("t5_rst_exec",  32'(bus.exec_en),  0);
    chk("t5_rst_state", 32'(dut.state_q),  32'(ST_IDLE));
    tick();
    rst_n = 1'b1;
    set_inst(9'h000, 1'b0, 1'b0, 1'b0);
    tick();

    // LUT was cleared by reset: branch on key 3 lands on 0.
    launch(10'd10);
    tick();
    set_inst(9'h003, 1'b1, 1'b0, 1'b0);
    tick();
    chk("t5_lut_reset", 32'(bus.pc_out), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter PC_W, default 10, program-counter width in bits.
REQ-002 Parameter LUT_N, default 32, number of branch-target entries, indexed by a 5-bit key.
REQ-003 Parameter MEM_TO, default 16, MEM_WAIT timeout in cycles.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle pulse; launches a program from start_addr.
REQ-007 start_addr  in  PC_W  initial PC value.
REQ-008 inst  in  9  instruction word from the synchronous instruction ROM, valid one cycle after pc_out changes.
REQ-009 branch_en  in  1  taken-branch flag from the decoder for the current inst.
REQ-010 memory_read_en, memory_write_en  in  1 each  memory-op flags from the decoder.
REQ-011 mem_ack  in  1  data memory completion strobe.
REQ-012 cfg_we  in  1  branch-LUT write enable.
REQ-013 cfg_idx  in  5  branch-LUT write index.
REQ-014 cfg_data  in  PC_W  branch-LUT write data.
REQ-015 pc_out  out  PC_W  current PC, registered.
REQ-016 exec_en  out  1  one-cycle commit strobe; gates register and memory side effects of inst.
REQ-017 mem_req  out  1  held high while a memory op is outstanding.
REQ-018 done  out  1  program halted normally.
REQ-019 err  out  1  memory timeout occurred.
REQ-020 instr_count  out  16  count of committed instructions.

Function
REQ-021 The FSM SHALL have states IDLE, FETCH, EXEC, MEM_WAIT and HALT.
REQ-022 IDLE: start -> pc_out=start_addr, instr_count=0, done=0, err=0, next FETCH; all other inputs ignored.
REQ-023 FETCH: lasts exactly one cycle (ROM latency), then EXEC.
REQ-024 EXEC, inst==9'h1FF (HALT): no commit; done=1; next HALT.
REQ-025 EXEC, memory_read_en or memory_write_en: mem_req=1 from the next cycle; next MEM_WAIT; exec_en=0.
REQ-026 EXEC, otherwise: exec_en=1 this cycle; PC update per REQ-028; next FETCH.
REQ-027 MEM_WAIT: mem_req=1. On mem_ack, exec_en=1 that cycle, mem_req drops next cycle, PC update, next FETCH. If MEM_TO cycles elapse without mem_ack, err=1, mem_req=0, next HALT with done=0.
REQ-028 PC update: branch_en ? lut[inst[4:0]] : pc_out+1, modulo 2^PC_W (all-ones wraps to 0).
REQ-029 instr_count SHALL increment on every exec_en and saturate at 16'hFFFF.
REQ-030 HALT: hold pc_out, done and err. start -> same action as IDLE start (restart).
REQ-031 start in FETCH/EXEC/MEM_WAIT SHALL be ignored.
REQ-032 LUT write: cfg_we writes cfg_data at cfg_idx in any state. A same-cycle read of the same index in EXEC returns the old value.
REQ-033 mem_ack outside MEM_WAIT SHALL be ignored.
REQ-034 exec_en and mem_req SHALL never be high together except in the mem_ack cycle.

Reset
REQ-035 rst_n low SHALL asynchronously force IDLE, pc_out=0, exec_en=0, mem_req=0, done=0, err=0, instr_count=0 and the timeout counter to 0.
REQ-036 LUT contents SHALL be reset to 0.
REQ-037 Reset asserted mid-MEM_WAIT SHALL drop mem_req immediately, with no commit.

Structure
REQ-038 A shared package SHALL hold the FSM state enum, HALT_INST=9'h1FF, and the PC_W/LUT_N defaults.
REQ-039 The LUT SHALL be a sub-module branch_lut: LUT_N x PC_W, 1 write port, 1 async read port.
REQ-040 The timeout counter SHALL be a $clog2(MEM_TO+1)-bit counter cleared on MEM_WAIT entry.

Verification
REQ-041 start_addr=5, three non-memory, non-branch insts then 9'h1FF -> pc_out 5,6,7,8; 3 exec_en pulses; done=1; instr_count=3.
REQ-042 lut[3]=0x40 written, branch inst with key 3 and branch_en=1 at pc 10 -> next pc_out=0x40.
REQ-043 Load at pc 2, mem_ack after 4 cycles -> mem_req high 4 cycles, exec_en in the ack cycle, pc_out=3.
REQ-044 Store with no mem_ack -> after 16 MEM_WAIT cycles: err=1, mem_req=0, state HALT, done=0.
REQ-045 pc_out=0x3FF, non-branch commit -> pc_out=0x000.
REQ-046 rst_n pulsed low mid-MEM_WAIT -> mem_req=0 and pc_out=0 without waiting for a clock edge; a start pulse during EXEC is ignored.
